// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Word width, bubble encoding and fetch FSM state encoding.
package fetch_pkg;
  localparam int XLEN = 16;
  typedef logic [XLEN-1:0] word_t;

  localparam word_t NOP_WORD = 16'hF000;

  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BUF   = 2'd2;

  function automatic word_t inc(word_t a);
    return a + 16'd1;
  endfunction
endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instruction/pc holding register.
// Keeps a returned instruction while ID is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] d_ir,
  input  logic [15:0] d_pc,
  output logic [15:0] q_ir,
  output logic [15:0] q_pc,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_ir  <= NOP_INSTR;
      q_pc  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      q_ir  <= d_ir;
      q_pc  <= d_pc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the pc, reads imem,
// feeds IF/ID and squashes wrong-path fetches.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC  = 16'h0000,
  parameter word_t NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] toPC,
  output logic [15:0] toPCInc,
  output logic [15:0] toIR,
  output logic        flush,
  output logic        IR_write
);

  logic [1:0] state;
  word_t      pc;
  logic       discard;

  word_t buf_ir;
  word_t buf_pc;
  logic  buf_valid;

  logic  in_wait;
  logic  hit;
  logic  avail;
  logic  do_redir;
  logic  do_stall;
  logic  do_acc;
  logic  buf_load;
  logic  buf_clear;
  word_t instr;
  word_t ipc;

  always_comb begin
    in_wait  = (state == S_WAIT);
    hit      = in_wait & imem_valid & ~discard;
    avail    = hit | buf_valid;
    instr    = buf_valid ? buf_ir : imem_rdata;
    ipc      = buf_valid ? buf_pc : pc;
    do_redir = redirect_valid;
    do_stall = ~redirect_valid & stall;
    do_acc   = ~redirect_valid & ~stall & avail;
    buf_load  = reset & do_stall & hit;
    buf_clear = reset & (do_redir | (do_acc & buf_valid));
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    toIR      = NOP_INSTR;
    toPC      = ipc;
    toPCInc   = inc(ipc);
    flush     = 1'b1;
    IR_write  = 1'b0;
    if (!reset) begin
      toPC    = RESET_PC;
      toPCInc = inc(RESET_PC);
    end else begin
      imem_req = (state == S_ISSUE) & ~redirect_valid;
      unique case (1'b1)
        do_redir: flush = 1'b1;
        do_stall: begin
          flush    = 1'b0;
          IR_write = 1'b1;
        end
        do_acc: begin
          flush = 1'b0;
          toIR  = instr;
        end
        default: flush = 1'b1;
      endcase
    end
  end

  // a redirect with a fetch still in flight must drop that response
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc      <= RESET_PC;
      state   <= S_ISSUE;
      discard <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      if (in_wait && !imem_valid) begin
        state   <= S_WAIT;
        discard <= 1'b1;
      end else begin
        state   <= S_ISSUE;
        discard <= 1'b0;
      end
    end else begin
      unique case (state)
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_ISSUE;
            end else if (stall) begin
              state <= S_BUF;
            end else begin
              pc    <= inc(pc);
              state <= S_ISSUE;
            end
          end
        end
        S_BUF: begin
          if (!stall) begin
            pc    <= inc(pc);
            state <= S_ISSUE;
          end
        end
        default: state <= S_ISSUE;
      endcase
    end
  end

  fetch_hold_buf #(
    .NOP_INSTR(NOP_INSTR)
  ) u_hold (
    .clk  (clk),
    .reset(reset),
    .load (buf_load),
    .clear(buf_clear),
    .d_ir (imem_rdata),
    .d_pc (pc),
    .q_ir (buf_ir),
    .q_pc (buf_pc),
    .valid(buf_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle vectors for fetch_unit.
// Each row drives one cycle and checks the combinational outputs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] toPC;
  logic [15:0] toPCInc;
  logic [15:0] toIR;
  logic        flush;
  logic        IR_write;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .toPC          (toPC),
    .toPCInc       (toPCInc),
    .toIR          (toIR),
    .flush         (flush),
    .IR_write      (IR_write)
  );

  typedef struct packed {
    logic        rst;
    logic        st;
    logic        rv;
    logic [15:0] rpc;
    logic        iv;
    logic [15:0] rd;
    logic        req;
    logic [15:0] addr;
    logic        fl;
    logic        irw;
    logic        chk;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] inc;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(
    logic rst, logic st, logic rv, logic [15:0] rpc,
    logic iv, logic [15:0] rd,
    logic req, logic [15:0] addr, logic fl, logic irw,
    logic chk, logic [15:0] ir, logic [15:0] pc, logic [15:0] inc);
    vec_t r;
    r = '{rst, st, rv, rpc, iv, rd, req, addr, fl, irw, chk, ir, pc, inc};
    return r;
  endfunction

  function automatic vec_t rq(logic [15:0] addr);
    return mk(1, 0, 0, 0, 0, 0, 1, addr, 1, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t acc(logic [15:0] d, logic [15:0] pc,
                               logic [15:0] inc);
    return mk(1, 0, 0, 0, 1, d, 0, 0, 0, 0, 1, d, pc, inc);
  endfunction

  task automatic chk1(string nm, int row, logic [15:0] act,
                      logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic apply(int row, vec_t t);
    @(negedge clk);
    reset          = t.rst;
    stall          = t.st;
    redirect_valid = t.rv;
    redirect_pc    = t.rpc;
    imem_valid     = t.iv;
    imem_rdata     = t.rd;
    #1;
    chk1("imem_req", row, {15'd0, imem_req}, {15'd0, t.req});
    if (t.req) chk1("imem_addr", row, imem_addr, t.addr);
    chk1("flush", row, {15'd0, flush}, {15'd0, t.fl});
    chk1("IR_write", row, {15'd0, IR_write}, {15'd0, t.irw});
    if (t.chk) begin
      chk1("toIR", row, toIR, t.ir);
      chk1("toPC", row, toPC, t.pc);
      chk1("toPCInc", row, toPCInc, t.inc);
    end
  endtask

  initial begin
    // reset held two cycles
    v.push_back(mk(0,0,0,0,0,0, 0,0,1,0, 1,16'hF000,16'h0000,16'h0001));
    v.push_back(mk(0,0,0,0,0,0, 0,0,1,0, 1,16'hF000,16'h0000,16'h0001));
    // straight-line, 1-cycle memory
    v.push_back(rq(16'h0000));
    v.push_back(acc(16'h1234, 16'h0000, 16'h0001));
    v.push_back(rq(16'h0001));
    v.push_back(acc(16'h5678, 16'h0001, 16'h0002));
    v.push_back(rq(16'h0002));
    v.push_back(acc(16'h1111, 16'h0002, 16'h0003));
    v.push_back(rq(16'h0003));
    v.push_back(acc(16'h2222, 16'h0003, 16'h0004));
    // stall capture at pc 4
    v.push_back(rq(16'h0004));
    v.push_back(mk(1,1,0,0,1,16'hABCD, 0,0,0,1, 0,0,0,0));
    v.push_back(mk(1,1,0,0,0,0, 0,0,0,1, 0,0,0,0));
    v.push_back(mk(1,1,0,0,0,0, 0,0,0,1, 0,0,0,0));
    v.push_back(mk(1,1,0,0,0,0, 0,0,0,1, 0,0,0,0));
    v.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1,16'hABCD,16'h0004,16'h0005));
    // redirect while waiting, 3-cycle memory
    v.push_back(rq(16'h0005));
    v.push_back(mk(1,0,0,0,0,0, 0,0,1,0, 0,0,0,0));
    v.push_back(mk(1,0,1,16'h0040,0,0, 0,0,1,0, 0,0,0,0));
    v.push_back(mk(1,0,0,0,1,16'hDEAD, 0,0,1,0, 0,0,0,0));
    v.push_back(rq(16'h0040));
    v.push_back(mk(1,0,0,0,0,0, 0,0,1,0, 0,0,0,0));
    v.push_back(acc(16'h4000, 16'h0040, 16'h0041));
    // redirect + stall + imem_valid together
    v.push_back(rq(16'h0041));
    v.push_back(mk(1,1,1,16'h0080,1,16'hBEEF, 0,0,1,0, 0,0,0,0));
    v.push_back(rq(16'h0080));
    v.push_back(acc(16'h8080, 16'h0080, 16'h0081));
    // wrap at 16'hFFFF
    v.push_back(mk(1,0,1,16'hFFFF,0,0, 0,0,1,0, 0,0,0,0));
    v.push_back(rq(16'hFFFF));
    v.push_back(acc(16'h7777, 16'hFFFF, 16'h0000));
    v.push_back(rq(16'h0000));
    v.push_back(acc(16'h0001, 16'h0000, 16'h0001));
    // reset while a fetch is outstanding
    v.push_back(rq(16'h0001));
    v.push_back(mk(0,0,0,0,0,0, 0,0,1,0, 1,16'hF000,16'h0000,16'h0001));
    v.push_back(rq(16'h0000));
    // redirect drops a buffered instruction
    v.push_back(mk(1,1,0,0,1,16'h1357, 0,0,0,1, 0,0,0,0));
    v.push_back(mk(1,1,1,16'h0010,0,0, 0,0,1,0, 0,0,0,0));
    v.push_back(rq(16'h0010));
    v.push_back(acc(16'h2468, 16'h0010, 16'h0011));

    for (int i = 0; i < v.size(); i++) apply(i, v[i]);

    // stall raised before the response: request still goes out,
    // then the late response is held until stall drops
    apply(100, mk(1,1,0,0,0,0, 1,16'h0011,0,1, 0,0,0,0));
    apply(101, mk(1,1,0,0,0,0, 0,0,0,1, 0,0,0,0));
    apply(102, mk(1,1,0,0,1,16'h9999, 0,0,0,1, 0,0,0,0));
    apply(103, mk(1,1,0,0,0,0, 0,0,0,1, 0,0,0,0));
    apply(104, mk(1,0,0,0,0,0, 0,0,0,0, 1,16'h9999,16'h0011,16'h0012));
    apply(105, rq(16'h0012));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
